vc_rr_arbiter: RTL and testbench

VC_RR_ARBITER -- requirements
Module: vc_rr_arbiter

---
 rtl/vc_rr_arbiter.sv | 104 ++++++++++
 tb/tb_vc_rr_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vc_rr_arbiter.sv
// Round-robin packet arbiter: grants one requester at a time and holds the grant until
// that requester strobes its release bit; priority rotates past the releasing requester.
module vc_rr_arbiter #(
  parameter int unsigned NUM_REQ = 64,
  parameter int unsigned ID_W    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] pkt_release,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    rel_ptr;
  logic [ID_W-1:0]    base;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_found;
  logic               rel_hit;
  logic               arb_go;

  // Binary index of the held grant (grant is one-hot or zero).
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_idx = gnt_idx | ID_W'(i);
    end
  end

  assign rel_hit = (state == LOCKED) && |(pkt_release & grant);
  assign arb_go  = enable && |req;
  assign rel_ptr = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
  assign base    = rel_hit ? rel_ptr : ptr;

  // First requester in circular order starting at base.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    pick_onehot = '0;
    pick_found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(base) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && req[ID_W'(idx)]) begin
        pick_found                = 1'b1;
        pick_onehot[ID_W'(idx)]   = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant       <= grant_nxt;
      grant_valid <= |grant_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_go) state_nxt = LOCKED;
      LOCKED:  if (rel_hit && !arb_go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next grant and pointer; ptr only moves on an honoured release.
  always_comb begin
    grant_nxt = grant;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: grant_nxt = arb_go ? pick_onehot : '0;
      LOCKED: begin
        if (rel_hit) begin
          ptr_nxt   = rel_ptr;
          grant_nxt = arb_go ? pick_onehot : '0;
        end
      end
      default: grant_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Self-checking bench for vc_rr_arbiter (8 requesters): directed vector table,
// asynchronous reset sequence and randomized traffic against an ownership model.
module tb_vc_rr_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [N-1:0] req;
  logic [N-1:0] pkt_release;
  logic [N-1:0] grant;
  logic         grant_valid;

  int checks;
  int errors;

  // Model: who owns the channel (-1 = nobody) and who has top priority.
  int m_owner;
  int m_ptr;

  typedef struct {
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] rel;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  vc_rr_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .req         (req),
    .pkt_release (pkt_release),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_from(input int p, input logic [N-1:0] r);
    int j;
    for (int k = 0; k < int'(N); k++) begin
      j = (p + k) % int'(N);
      if (r[j[IW-1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] one;
    one = 1;
    return (m_owner < 0) ? '0 : (one << m_owner);
  endfunction

  task automatic model_step(input logic en, input logic [N-1:0] r, input logic [N-1:0] rl);
    if (m_owner < 0) begin
      if (en && r != 0) m_owner = first_from(m_ptr, r);
    end else if (rl[m_owner]) begin
      m_ptr   = (m_owner + 1) % int'(N);
      m_owner = (en && r != 0) ? first_from(m_ptr, r) : -1;
    end
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, advance the model, settle off the edge.
  task automatic cycle(input logic en, input logic [N-1:0] r, input logic [N-1:0] rl);
    enable      = en;
    req         = r;
    pkt_release = rl;
    @(posedge clk);
    model_step(en, r, rl);
    #1;
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] rl;
    logic         en;

    checks  = 0;
    errors  = 0;
    m_owner = -1;
    m_ptr   = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    req         = '0;
    pkt_release = '0;

    // en, req, release, expected grant after the edge
    vecs.push_back('{1'b1, 8'b0010_0100, 8'b0000_0000, 8'b0000_0100});
    vecs.push_back('{1'b1, 8'b1111_1011, 8'b0000_0000, 8'b0000_0100});
    vecs.push_back('{1'b0, 8'b0000_0000, 8'b0000_0000, 8'b0000_0100});
    vecs.push_back('{1'b1, 8'b0010_0101, 8'b0000_0100, 8'b0010_0000});
    vecs.push_back('{1'b1, 8'b0010_0101, 8'b0010_0000, 8'b0000_0001});
    vecs.push_back('{1'b1, 8'b0000_0000, 8'b0000_0001, 8'b0000_0000});
    vecs.push_back('{1'b1, 8'b1000_0000, 8'b0000_0000, 8'b1000_0000});
    vecs.push_back('{1'b1, 8'b1000_0010, 8'b1000_0000, 8'b0000_0010});
    vecs.push_back('{1'b1, 8'b1000_0000, 8'b0000_0010, 8'b1000_0000});
    vecs.push_back('{1'b1, 8'b1000_0000, 8'b1000_0000, 8'b1000_0000});
    vecs.push_back('{1'b0, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 8'hFF, 8'b0000_0000, 8'b0000_0000});
    vecs.push_back('{1'b1, 8'hFF, 8'b0000_0000, 8'b0000_0001});
    vecs.push_back('{1'b0, 8'hFF, 8'b0000_0001, 8'b0000_0000});
    vecs.push_back('{1'b1, 8'b0000_1000, 8'b0000_0000, 8'b0000_1000});
    vecs.push_back('{1'b1, 8'hFF, 8'b1111_0111, 8'b0000_1000});
    vecs.push_back('{1'b1, 8'hFF, 8'b1111_0111, 8'b0000_1000});
    vecs.push_back('{1'b1, 8'hFF, 8'b0000_1000, 8'b0001_0000});
    vecs.push_back('{1'b1, 8'b0000_0000, 8'b0001_0000, 8'b0000_0000});

    // Reset state, including with the clock running.
    #2;
    check("reset_grant", grant, '0);
    check("reset_valid", N'(grant_valid), '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_grant_clk", grant, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", grant, '0);

    foreach (vecs[i]) begin
      cycle(vecs[i].en, vecs[i].req, vecs[i].rel);
      check($sformatf("vec%0d_grant", i), grant, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), N'(grant_valid), N'(vecs[i].exp != 0));
    end

    // Lock on 4 (ptr is 5 here, so 4 is reached after wrapping), then async reset mid-packet.
    cycle(1'b1, 8'b0001_0000, 8'b0000_0000);
    check("lock4_grant", grant, 8'b0001_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", grant, '0);
    check("async_rst_valid", N'(grant_valid), '0);
    m_owner = -1;
    m_ptr   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'b0001_0001, 8'b0000_0000);
    check("post_rst_ptr0", grant, 8'b0000_0001);
    check("post_rst_valid", N'(grant_valid), 8'b0000_0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 3) != 0);
      r  = N'($urandom) & N'($urandom);
      rl = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
      if (m_owner >= 0 && $urandom_range(0, 2) == 0) rl[m_owner] = 1'b1;
      cycle(en, r, rl);
      check($sformatf("rand%0d_grant", i), grant, model_grant());
      check($sformatf("rand%0d_valid", i), N'(grant_valid), N'(m_owner >= 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
